// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the
// serial BCD add/subtract controller.
package bcd_pkg;

    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RECOMP,
        DONE
    } state_t;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return 4'(BCD_MAX) - d;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle between the operand registers, the BCD
// sequencer and the display logic.
interface bcd_serial_addsub_if #(
    parameter int NDIG = 4
);

    logic              start;
    logic              op_sub;
    logic [4*NDIG-1:0] a;
    logic [4*NDIG-1:0] b;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] sum;
    logic              cout;
    logic              neg;
    logic              err;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, sum, cout, neg, err
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, sum, cout, neg, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add, then +6 correction above nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] t;
    logic [4:0] tc;

    assign t  = 5'(a) + 5'(b) + 5'(cin);
    assign tc = t + 5'(BCD_CORR);

    always_comb begin
        if (t > 5'(BCD_MAX)) begin
            s    = tc[3:0];
            cout = 1'b1;
        end else begin
            s    = t[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract sequencer, LSD first, with a second
// recomplement pass so negative differences come out as magnitudes.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input logic clk,
    input logic rst,
    bcd_serial_addsub_if.slave bus
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int W  = 4 * NDIG;

    state_t         state, state_n;
    logic [W-1:0]   a_q, a_n;
    logic [W-1:0]   b_q, b_n;
    logic [W-1:0]   sum_q, sum_n;
    logic           sub_q, sub_n;
    logic           cout_q, cout_n;
    logic           neg_q, neg_n;
    logic           err_q, err_n;
    logic           carry_q, carry_n;
    logic [IW-1:0]  idx, idx_n;

    logic [3:0]     da, db, ds;
    logic           dc;
    logic           last;
    logic           bad;
    logic [W-1:0]   b_in;

    bcd_digit_add u_dig (
        .a    (da),
        .b    (db),
        .cin  (carry_q),
        .s    (ds),
        .cout (dc)
    );

    assign last = (idx == IW'(NDIG - 1));

    // RECOMP feeds the raw result back as 9-sum[i] with no second operand
    always_comb begin
        if (state == RECOMP) begin
            da = nines(sum_q[idx*4 +: 4]);
            db = 4'd0;
        end else begin
            da = a_q[idx*4 +: 4];
            db = b_q[idx*4 +: 4];
        end
    end

    always_comb begin
        bad  = 1'b0;
        b_in = '0;
        for (int i = 0; i < NDIG; i++) begin
            bad = bad | (bus.a[i*4 +: 4] > 4'(BCD_MAX))
                      | (bus.b[i*4 +: 4] > 4'(BCD_MAX));
            b_in[i*4 +: 4] = bus.op_sub ? nines(bus.b[i*4 +: 4])
                                        : bus.b[i*4 +: 4];
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum_q;
        sub_n   = sub_q;
        cout_n  = cout_q;
        neg_n   = neg_q;
        err_n   = err_q;
        carry_n = carry_q;
        idx_n   = idx;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = b_in;
                    sub_n   = bus.op_sub;
                    sum_n   = '0;
                    cout_n  = 1'b0;
                    neg_n   = 1'b0;
                    err_n   = bad;
                    carry_n = bus.op_sub;
                    idx_n   = '0;
                    state_n = ADD;
                end
            end
            ADD: begin
                if (err_q) begin
                    state_n = DONE;
                end else begin
                    sum_n[idx*4 +: 4] = ds;
                    carry_n = dc;
                    idx_n   = idx + 1'b1;
                    if (last) begin
                        idx_n   = '0;
                        state_n = DONE;
                        if (!sub_q) begin
                            cout_n = dc;
                        end else if (!dc) begin
                            neg_n   = 1'b1;
                            carry_n = 1'b1;
                            state_n = RECOMP;
                        end
                    end
                end
            end
            RECOMP: begin
                sum_n[idx*4 +: 4] = ds;
                carry_n = dc;
                idx_n   = idx + 1'b1;
                if (last) begin
                    idx_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else begin
            state   <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sum_q   <= sum_n;
            sub_q   <= sub_n;
            cout_q  <= cout_n;
            neg_q   <= neg_n;
            err_q   <= err_n;
            carry_q <= carry_n;
            idx     <= idx_n;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed-vector bench for the serial BCD add/subtract sequencer.
module tb_bcd_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   lat;
    logic bsy;

    bcd_serial_addsub_if #(.NDIG(4)) bus ();

    bcd_serial_addsub #(.NDIG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // latency = edges after the start-sampling edge until done is seen
    task automatic run(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input int glitch,
                       output int l, output logic busy_ok);
        @(negedge clk);
        bus.a = ta;
        bus.b = tb_;
        bus.op_sub = ts;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        l = 99;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                l = k;
                if (!bus.busy) busy_ok = 1'b0;
                break;
            end
            if (k == glitch) begin
                bus.a = 16'h1111;
                bus.b = 16'h2222;
                bus.op_sub = 1'b1;
                bus.start = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic [15:0] s,
                       input logic c, input logic n, input logic e);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(c));
        chk({tag, "_neg"}, 32'(bus.neg), 32'(n));
        chk({tag, "_err"}, 32'(bus.err), 32'(e));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        res("rst", 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        run(16'h1234, 16'h8766, 1'b0, 0, lat, bsy);
        chk("add1_lat", 32'(lat), 4);
        chk("add1_busy", 32'(bsy), 1);
        res("add1", 16'h0000, 1, 0, 0);

        run(16'h0999, 16'h0001, 1'b0, 0, lat, bsy);
        chk("add2_lat", 32'(lat), 4);
        res("add2", 16'h1000, 0, 0, 0);

        run(16'h5000, 16'h1234, 1'b1, 0, lat, bsy);
        chk("sub1_lat", 32'(lat), 4);
        res("sub1", 16'h3766, 0, 0, 0);

        run(16'h0042, 16'h0042, 1'b1, 0, lat, bsy);
        chk("sub2_lat", 32'(lat), 4);
        res("sub2", 16'h0000, 0, 0, 0);

        run(16'h1234, 16'h5000, 1'b1, 0, lat, bsy);
        chk("sub3_lat", 32'(lat), 8);
        chk("sub3_busy", 32'(bsy), 1);
        res("sub3", 16'h3766, 0, 1, 0);

        run(16'h12A4, 16'h0001, 1'b0, 0, lat, bsy);
        chk("err_lat", 32'(lat), 1);
        res("err", 16'h0000, 0, 0, 1);

        run(16'h0999, 16'h0001, 1'b0, 2, lat, bsy);
        chk("glitch_lat", 32'(lat), 4);
        chk("glitch_idle", 32'(bus.busy), 0);
        res("glitch", 16'h1000, 0, 0, 0);

        @(negedge clk);
        bus.a = 16'h5000;
        bus.b = 16'h1234;
        bus.op_sub = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_sum", 32'(bus.sum), 32'h0066);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_done", 32'(bus.done), 0);
        res("mrst", 16'h0000, 0, 0, 0);
        bsy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) bsy = 1'b1;
        end
        chk("mrst_nodone", 32'(bsy), 0);
        @(negedge clk);
        rst = 1'b0;

        run(16'h1234, 16'h8766, 1'b0, 0, lat, bsy);
        chk("post_lat", 32'(lat), 4);
        res("post", 16'h0000, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
